// File: rtl/memory_responder_pkg.sv
// Shared types for the eightbit CPU memory path plus the MMIO page address map.
// The MMIO page occupies the four addresses 0xFFF0..0xFFF3; everything else is RAM.
package memory_responder_pkg;

   typedef enum logic [2:0] {
      REG_NOP,
      REG_LOAD_A,
      REG_LOAD_B,
      REG_LOAD_IR,
      REG_LOAD_PC,
      REG_INC_PC
   } reg_op_t;

   typedef enum logic [1:0] {
      MEMALU_NOP,
      MEMALU_FETCH,
      MEMALU_LOAD,
      MEMALU_STORE
   } memalu_op_t;

   localparam logic [15:0] MMIO_TX      = 16'hFFF0;
   localparam logic [15:0] MMIO_STATUS  = 16'hFFF1;
   localparam logic [15:0] MMIO_TICK_LO = 16'hFFF2;
   localparam logic [15:0] MMIO_TICK_HI = 16'hFFF3;

   function automatic logic is_mmio(input logic [15:0] a);
      return a[15:2] == MMIO_TX[15:2];
   endfunction

endpackage

// File: rtl/memory_responder_tx_fifo.sv
// Transmit FIFO: head visible combinationally, push lands one cycle later (no bypass).
// A push while full is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_cnt;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full     = (r_cnt == FULL_CNT);
   assign o_empty    = (r_cnt == '0);
   assign w_pop_ok   = i_pop & ~o_empty;
   assign w_push_ok  = i_push & (~o_full | w_pop_ok);
   assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/memory_responder.sv
// CPU-side memory responder: strobe captures address and read data, data valid the next cycle.
// Writes commit at the data-phase edge; TX stream follows valid/ready, overflow drops data.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int DEPTH      = 4096,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_bus,
   input  logic        address_read,
   input  logic        mem_enable,
   input  logic        data_in,
   input  logic        data_out,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        protocol_error
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_ram [DEPTH];
   logic [15:0] r_addr;
   logic [7:0]  r_rd;
   logic [15:0] r_tick;
   logic [7:0]  r_snap;
   logic        r_ovf;
   logic        r_perr;

   logic        w_rd_phase;
   logic        w_wr_phase;
   logic        w_clash;
   logic        w_wr_ram;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic        w_drop;
   logic [7:0]  w_map;

   assign w_rd_phase = mem_enable & data_in;
   assign w_wr_phase = mem_enable & data_out & ~data_in & ~reset;
   assign w_clash    = mem_enable & data_in & data_out;
   assign w_wr_ram   = w_wr_phase & ~is_mmio(r_addr);
   assign w_push     = w_wr_phase & (r_addr == MMIO_TX);
   assign w_pop      = tx_valid & tx_ready;
   assign w_drop     = w_push & w_full & ~w_pop;

   assign rdata          = w_rd_phase ? r_rd : 8'h00;
   assign tx_valid       = ~w_empty;
   assign protocol_error = r_perr;

   // MMIO values reflect state before the strobe edge, so same-cycle pushes are not seen.
   always_comb begin
      w_map = 8'h00;
      case (addr_bus)
         MMIO_TX:      w_map = 8'h00;
         MMIO_STATUS:  w_map = {5'b0, r_ovf, w_empty, w_full};
         MMIO_TICK_LO: w_map = r_tick[7:0];
         MMIO_TICK_HI: w_map = r_snap;
         default:      w_map = r_ram[addr_bus[AW-1:0]];
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr_ram) r_ram[r_addr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr <= 16'h0000;
         r_rd   <= 8'h00;
         r_tick <= 16'h0000;
         r_snap <= 8'h00;
         r_ovf  <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         r_tick <= r_tick + 16'd1;
         if (address_read) begin
            r_addr <= addr_bus;
            r_rd   <= w_map;
            if (addr_bus == MMIO_TICK_LO) r_snap <= r_tick[15:8];
         end
         // A drop in the same cycle as a status read wins, so no overflow is lost.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (address_read && (addr_bus == MMIO_STATUS)) begin
            r_ovf <= 1'b0;
         end
         if (w_clash) r_perr <= 1'b1;
      end
   end

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_push     (w_push),
      .i_push_dat (wdata),
      .i_pop      (w_pop),
      .o_head_dat (tx_data),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: RAM round trip, aliasing, TX FIFO, tick snapshot, errors, reset.
module tb_memory_responder;
   import memory_responder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr_bus;
   logic        address_read;
   logic        mem_enable;
   logic        data_in;
   logic        data_out;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        protocol_error;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   memory_responder #(
      .DEPTH      (4096),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .addr_bus       (addr_bus),
      .address_read   (address_read),
      .mem_enable     (mem_enable),
      .data_in        (data_in),
      .data_out       (data_out),
      .wdata          (wdata),
      .rdata          (rdata),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .protocol_error (protocol_error)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      address_read = 1'b0;
      mem_enable   = 1'b0;
      data_in      = 1'b0;
      data_out     = 1'b0;
   endtask

   task automatic strobe(input logic [15:0] a);
      idle();
      address_read = 1'b1;
      addr_bus     = a;
      step();
      idle();
   endtask

   task automatic wr(input logic [7:0] d);
      idle();
      mem_enable = 1'b1;
      data_out   = 1'b1;
      wdata      = d;
      step();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] exp);
      idle();
      mem_enable = 1'b1;
      data_in    = 1'b1;
      #1;
      check(tag, 16'(rdata), 16'(exp));
      step();
      idle();
   endtask

   task automatic apply_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      addr_bus = 16'h0000;
      wdata    = 8'h00;
      tx_ready = 1'b0;
      idle();
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_rdata",    16'(rdata),          16'h0000);
      check("rst_tx_valid", 16'(tx_valid),       16'h0000);
      check("rst_tx_data",  16'(tx_data),        16'h0000);
      check("rst_perr",     16'(protocol_error), 16'h0000);
      rd_chk("rst_rd_reg", 8'h00);

      // RAM round trip and aliasing at DEPTH=4096
      strobe(16'h0010); wr(8'hA5);
      strobe(16'h0010); rd_chk("ram_0010", 8'hA5);
      strobe(16'h1010); rd_chk("alias_1010", 8'hA5);
      strobe(16'h1010); wr(8'h5A);
      strobe(16'h0010); rd_chk("alias_wr_0010", 8'h5A);
      strobe(16'h0FFF); wr(8'h3C);
      strobe(16'hFFFF); rd_chk("alias_ffff", 8'h3C);

      // Overflow: five pushes into a four-deep FIFO with no drain
      strobe(MMIO_TX);
      idle(); mem_enable = 1'b1; data_out = 1'b1; wdata = 8'h11;
      #1;
      check("push_no_bypass", 16'(tx_valid), 16'h0000);
      step(); idle();
      check("push_valid", 16'(tx_valid), 16'h0001);
      check("push_head",  16'(tx_data),  16'h0011);
      wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
      strobe(MMIO_STATUS); rd_chk("status_ovf", 8'h05);
      strobe(MMIO_STATUS); rd_chk("status_clr", 8'h01);
      strobe(MMIO_STATUS); wr(8'hFF);
      strobe(MMIO_STATUS); rd_chk("status_wr_ignored", 8'h01);
      strobe(MMIO_TX); rd_chk("tx_reads_zero", 8'h00);

      // Drain in FIFO order, one pop per cycle
      idle(); tx_ready = 1'b1;
      #1;
      check("drain0", 16'(tx_data), 16'h0011);
      step(); check("drain1", 16'(tx_data), 16'h0022);
      step(); check("drain2", 16'(tx_data), 16'h0033);
      step(); check("drain3", 16'(tx_data), 16'h0044);
      step();
      check("drain_valid", 16'(tx_valid), 16'h0000);
      check("drain_data",  16'(tx_data),  16'h0000);
      tx_ready = 1'b0;
      strobe(MMIO_STATUS); rd_chk("status_empty", 8'h02);

      // Counter coherence: the strobe edge 256 edges after reset samples 0x00FF
      apply_reset();
      repeat (255) step();
      strobe(MMIO_TICK_LO); rd_chk("tick_lo", 8'hFF);
      strobe(MMIO_TICK_HI); rd_chk("tick_hi_snap", 8'h00);
      repeat (5) step();
      strobe(MMIO_TICK_HI); rd_chk("tick_hi_hold", 8'h00);

      // Protocol error: read and write phase together is a read only
      strobe(16'h0020); wr(8'h77);
      strobe(16'h0020);
      idle(); mem_enable = 1'b1; data_in = 1'b1; data_out = 1'b1; wdata = 8'h99;
      #1;
      check("clash_rdata", 16'(rdata), 16'h0077);
      step(); idle();
      check("perr_set", 16'(protocol_error), 16'h0001);
      repeat (3) step();
      check("perr_sticky", 16'(protocol_error), 16'h0001);
      strobe(16'h0020); rd_chk("clash_ram_kept", 8'h77);

      // Reset coinciding with a store
      strobe(MMIO_TX); wr(8'h66);
      check("pre_rst_valid", 16'(tx_valid), 16'h0001);
      strobe(16'h0030); wr(8'h42);
      strobe(16'h0030);
      idle(); mem_enable = 1'b1; data_out = 1'b1; wdata = 8'hEE; reset = 1'b1;
      step();
      reset = 1'b0; idle();
      #1;
      check("mid_rst_valid", 16'(tx_valid),       16'h0000);
      check("mid_rst_data",  16'(tx_data),        16'h0000);
      check("mid_rst_perr",  16'(protocol_error), 16'h0000);
      check("mid_rst_rdata", 16'(rdata),          16'h0000);
      rd_chk("mid_rst_rd_reg", 8'h00);
      wr(8'hC3);
      strobe(16'h0030); rd_chk("mid_rst_ram_kept", 8'h42);
      strobe(16'h0000); rd_chk("no_strobe_addr0", 8'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Bus-side memory responder for the eightbit CPU: the far end of the control sequencer's memory handshake (`address_read`, `mem_enable`, `data_in`, `data_out`). It latches addresses, serves reads from a synchronous RAM with the one-cycle latency the sequencer's fetch, load and store sequences expect, and commits writes. The top of the address space holds a small MMIO page: a transmit FIFO with a valid/ready output stream, a status register, and a free-running tick counter.

## Interface
Parameters:
- `DEPTH`, 4096: RAM bytes; power of two, at most 65536.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr_bus`  in  16  address driven by the CPU; sampled when `address_read` is high.
- `address_read`  in  1  address strobe.
- `mem_enable`  in  1  data-phase enable.
- `data_in`  in  1  CPU read phase; this block drives data.
- `data_out`  in  1  CPU write phase; this block accepts data.
- `wdata`  in  8  CPU write data.
- `rdata`  out  8  read data; valid while `mem_enable & data_in`, otherwise 0x00.
- `tx_data`  out  8  FIFO head.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  downstream accepts the head.
- `protocol_error`  out  1  sticky error flag; cleared only by reset.

## Operation
- Address map:
  - 0xFFF0: TX push on write; reads 0x00.
  - 0xFFF1: status on read (bit0 full, bit1 empty, bit2 overflow, others 0); writes ignored.
  - 0xFFF2: counter low byte on read; the read also snapshots the counter high byte.
  - 0xFFF3: the snapshotted high byte.
  - All other addresses: RAM at index `addr % DEPTH`.
- Address strobe:
  - `addr_reg <= addr_bus`.
  - `rd_reg <=` the mapped value at `addr_bus`: a RAM read or an MMIO mux.
  - Reading 0xFFF1 this way clears overflow after the captured value is returned.
- Read phase (`mem_enable & data_in`): `rdata = rd_reg`. There are no side effects.
- Write phase (`mem_enable & data_out & ~data_in`): `wdata` is written to `addr_reg` at the clock edge.
- Both `data_in` and `data_out` high: treated as a read only, no write, `protocol_error <= 1`.
- `mem_enable` with no prior strobe uses the last `addr_reg` (0x0000 after reset).
- Tick counter: 16 bits, increments every cycle, wraps 0xFFFF→0x0000.
- FIFO push when full:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the data is dropped and overflow is set.
- Pop: `tx_valid & tx_ready`, once per cycle, FIFO order. A push into an empty FIFO gives no bypass; `tx_valid` rises the next cycle.
- Reset values: `addr_reg` 0x0000, `rd_reg` 0x00, `rdata` 0x00, FIFO empty, `tx_valid` 0, `tx_data` 0x00, counter 0, snapshot 0, overflow 0, `protocol_error` 0. RAM contents are not reset.
- A write phase coinciding with `reset` is suppressed.

## Timing
- Read latency: the strobe in cycle N makes data valid in cycle N+1. This matches fetch (A→C) and load (LODB→LODC).
- Writes commit at the edge ending the data-phase cycle (STOC), so a readback strobe in the next cycle sees the new value.
- A strobe to 0xFFF2 in cycle N returns the counter value at cycle N. The snapshot taken at the same edge guarantees a coherent high/low pair.
- FIFO status is sampled at the strobe edge. A push in the same cycle is not reflected.

## Structure
- The shared package already holds `reg_op_t` and `memalu_op_t`. Add these address constants there: `MMIO_TX` 0xFFF0, `MMIO_STATUS` 0xFFF1, `MMIO_TICK_LO` 0xFFF2, `MMIO_TICK_HI` 0xFFF3.
- Sub-module `tx_fifo`: parameterised depth, push/pop/full/empty, head-out.
- Everything else stays in `memory_responder`: address decode, RAM, counter, error logic.

## Test plan
- RAM round trip: write 0xA5 to 0x0010 (strobe then write phase), then strobe 0x0010 → `rdata`=0xA5 in the following read-phase cycle. Check that 0x1010 aliases when `DEPTH`=4096.
- Overflow: with `tx_ready`=0, push 0x11, 0x22, 0x33, 0x44, 0x55 → the first status read returns 0x05 and the next returns 0x01.
- Drain: raise `tx_ready`=1 → `tx_data` shows 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `tx_valid`=0 and status 0x02.
- Counter coherence: strobe 0xFFF2 when the counter is 0x00FF → low=0xFF, and a later read of 0xFFF3 returns 0x00, not 0x01.
- Protocol error: `data_in`=`data_out`=1 at 0x0020 → RAM unchanged, `protocol_error`=1 and it stays 1 until reset.
- Reset mid-store: `reset`=1 in the STOC cycle → the RAM byte keeps its old value and all outputs show their reset values the next cycle.
